// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arbState_t;

    // Requester IDs double as bit positions in the picker's one-hot winner.
    localparam logic [1:0] REQ_F = 2'd0;
    localparam logic [1:0] REQ_D = 2'd1;
    localparam logic [1:0] REQ_S = 2'd2;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational priority picker: D > S > F, with fetch pulled to the top when starving.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       fReq,
    input  logic       dReq,
    input  logic       sReq,
    input  logic       starve,
    output logic [2:0] winner,
    output logic       valid
);

    always_comb begin
        winner = 3'b000;
        valid  = fReq | dReq | sReq;
        if (starve && fReq) begin
            winner[REQ_F] = 1'b1;
        end else if (dReq) begin
            winner[REQ_D] = 1'b1;
        end else if (sReq) begin
            winner[REQ_S] = 1'b1;
        end else if (fReq) begin
            winner[REQ_F] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, data and stack requesters.
// One access outstanding at a time; fetch gets a boost after repeated losses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              s_req,
    input  logic              s_we,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              f_gnt,
    output logic              d_gnt,
    output logic              s_gnt,
    output logic              f_rvalid,
    output logic              d_rvalid,
    output logic              s_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    arbState_t         state;
    arbState_t         nextState;
    logic [1:0]        winnerId;
    logic              weReg;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataReg;
    logic [2:0]        latCnt;
    logic [SW-1:0]     starveCnt;
    logic              starveFlag;
    logic              pickValid;
    logic [2:0]        pickWinner;

    assign starveFlag = (STARVE_LIMIT != 0) && (starveCnt == SW'(STARVE_LIMIT));

    mem_arb_pick uPick (
        .fReq   (f_req),
        .dReq   (d_req),
        .sReq   (s_req),
        .starve (starveFlag),
        .winner (pickWinner),
        .valid  (pickValid)
    );

    // State register plus the captured access; the winner's request is latched
    // in IDLE so the requester may drop req once it has seen its grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            winnerId  <= REQ_F;
            weReg     <= 1'b0;
            addrReg   <= '0;
            wdataReg  <= '0;
            latCnt    <= '0;
            starveCnt <= '0;
        end else begin
            state <= nextState;

            if (state == IDLE && pickValid) begin
                if (pickWinner[REQ_D]) begin
                    winnerId <= REQ_D;
                    weReg    <= d_we;
                    addrReg  <= d_addr;
                    wdataReg <= d_wdata;
                end else if (pickWinner[REQ_S]) begin
                    winnerId <= REQ_S;
                    weReg    <= s_we;
                    addrReg  <= s_addr;
                    wdataReg <= s_wdata;
                end else begin
                    winnerId <= REQ_F;
                    weReg    <= 1'b0;
                    addrReg  <= f_addr;
                    wdataReg <= '0;
                end
            end

            if (state == ISSUE) begin
                latCnt <= 3'(RD_LAT);
            end else if (state == WAIT_RD) begin
                latCnt <= latCnt - 3'd1;
            end

            // Counts D/S grants that fetch had to sit through; any idle fetch cycle resets it.
            if (!f_req) begin
                starveCnt <= '0;
            end else if (state == ISSUE) begin
                if (winnerId == REQ_F) begin
                    starveCnt <= '0;
                end else if (starveCnt != SW'(STARVE_LIMIT)) begin
                    starveCnt <= starveCnt + SW'(1);
                end
            end
        end
    end

    // Next-state and strobe decode; grants and rvalids are steered by the latched winner.
    always_comb begin
        nextState = state;
        f_gnt     = 1'b0;
        d_gnt     = 1'b0;
        s_gnt     = 1'b0;
        f_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        s_rvalid  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (pickValid) begin
                    nextState = ISSUE;
                end
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_we    = weReg;
                f_gnt     = (winnerId == REQ_F);
                d_gnt     = (winnerId == REQ_D);
                s_gnt     = (winnerId == REQ_S);
                nextState = weReg ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (latCnt == 3'd1) begin
                    f_rvalid  = (winnerId == REQ_F);
                    d_rvalid  = (winnerId == REQ_D);
                    s_rvalid  = (winnerId == REQ_S);
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign mem_addr  = addrReg;
    assign mem_wdata = wdataReg;
    assign rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) share the requesters
// and are checked every cycle against a schedule-based model, plus directed vectors.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int NINST = 2;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    logic fReq, dReq, sReq, dWe, sWe;
    logic [31:0] fAddr, dAddr, sAddr, dWdata, sWdata;

    wire [NINST-1:0] gntF, gntD, gntS, rvF, rvD, rvS, busy, memEn, memWe;
    wire [31:0] rdata [NINST];
    wire [31:0] memAddr [NINST];
    wire [31:0] memWdata [NINST];
    wire [31:0] memRdata [NINST];

    int testsRun = 0;
    int failCount = 0;
    bit chkEn = 1'b0;

    typedef struct {
        bit          f, d, s, dw, sw;
        logic [2:0]  expGnt;
        bit          expWe;
        logic [31:0] expAddr;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    function automatic logic [31:0] memFunc(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h0000A5A5;
    endfunction

    function automatic logic [2:0] fds(input int id);
        case (id)
            0: return 3'b100;
            1: return 3'b010;
            2: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit f, input bit d, input bit s, input bit dw, input bit sw);
        fReq = f;
        dReq = d;
        sReq = s;
        dWe  = dw;
        sWe  = sw;
    endtask

    for (genvar k = 0; k < NINST; k++) begin : gInst
        localparam int LAT = (k == 0) ? 1 : 3;
        logic [31:0] pipe [4];

        mem_port_arbiter #(
            .ADDR_W(32), .DATA_W(32), .RD_LAT(LAT), .STARVE_LIMIT(LIMIT)
        ) dut (
            .clk(clk), .rst(rst),
            .f_req(fReq), .f_addr(fAddr),
            .d_req(dReq), .d_we(dWe), .d_addr(dAddr), .d_wdata(dWdata),
            .s_req(sReq), .s_we(sWe), .s_addr(sAddr), .s_wdata(sWdata),
            .f_gnt(gntF[k]), .d_gnt(gntD[k]), .s_gnt(gntS[k]),
            .f_rvalid(rvF[k]), .d_rvalid(rvD[k]), .s_rvalid(rvS[k]),
            .rdata(rdata[k]), .busy(busy[k]),
            .mem_en(memEn[k]), .mem_we(memWe[k]),
            .mem_addr(memAddr[k]), .mem_wdata(memWdata[k]), .mem_rdata(memRdata[k])
        );

        // Memory with LAT-cycle read latency whose contents are a fixed function of the address.
        always @(posedge clk) begin
            pipe[0] <= (memEn[k] && !memWe[k]) ? memFunc(memAddr[k]) : 32'h0;
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end
        assign memRdata[k] = pipe[LAT-1];

        // Reference model: on each arbitration it books the grant, busy and rvalid cycles ahead.
        int mCyc = 0;
        int nextFree = 0;
        int starve = 0;
        int schGnt [8];
        int schRv [8];
        bit schBusy [8];
        bit schWe [8];
        logic [31:0] schRvAddr [8];
        logic [31:0] curAddr = 32'h0;
        logic [31:0] curWdata = 32'h0;

        initial begin
            for (int i = 0; i < 8; i++) begin
                schGnt[i] = -1; schRv[i] = -1; schBusy[i] = 1'b0; schWe[i] = 1'b0; schRvAddr[i] = 32'h0;
            end
        end

        always @(negedge clk) begin
            int slot, g, w;
            logic wr, expWe;
            logic [31:0] ad, wd;
            logic [2:0] expG, expR;
            slot  = mCyc % 8;
            g     = schGnt[slot];
            expG  = fds(g);
            expR  = fds(schRv[slot]);
            expWe = (g >= 0) && schWe[slot];
            if (chkEn) begin
                checkOutput($sformatf("inst%0d cycle %0d strobes", k, mCyc),
                    128'({gntF[k], gntD[k], gntS[k], rvF[k], rvD[k], rvS[k], busy[k], memEn[k], memWe[k],
                          memAddr[k], (memWe[k] ? memWdata[k] : 32'h0)}),
                    128'({expG, expR, schBusy[slot], (g >= 0), expWe, curAddr, (expWe ? curWdata : 32'h0)}));
                if (expR != 3'b000)
                    checkOutput($sformatf("inst%0d cycle %0d rdata", k, mCyc),
                        128'(rdata[k]), 128'(memFunc(schRvAddr[slot])));
            end
            schGnt[slot] = -1; schRv[slot] = -1; schBusy[slot] = 1'b0; schWe[slot] = 1'b0;
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    schGnt[i] = -1; schRv[i] = -1; schBusy[i] = 1'b0; schWe[i] = 1'b0;
                end
                nextFree = mCyc + 1;
                starve   = 0;
                curAddr  = 32'h0;
                curWdata = 32'h0;
            end else begin
                w = -1;
                if (mCyc >= nextFree && (fReq || dReq || sReq)) begin
                    if (LIMIT != 0 && starve == LIMIT && fReq) w = 0;
                    else if (dReq) w = 1;
                    else if (sReq) w = 2;
                    else w = 0;
                end
                if (!fReq) starve = 0;
                else if (g == 0) starve = 0;
                else if (g > 0 && starve < LIMIT) starve++;
                if (w >= 0) begin
                    wr = (w == 1) ? dWe : (w == 2) ? sWe : 1'b0;
                    ad = (w == 1) ? dAddr : (w == 2) ? sAddr : fAddr;
                    wd = (w == 1) ? dWdata : (w == 2) ? sWdata : 32'h0;
                    schGnt[(mCyc + 1) % 8]  = w;
                    schWe[(mCyc + 1) % 8]   = wr;
                    schBusy[(mCyc + 1) % 8] = 1'b1;
                    curAddr  = ad;
                    curWdata = wd;
                    if (wr) begin
                        nextFree = mCyc + 2;
                    end else begin
                        for (int i = 2; i <= LAT + 1; i++) schBusy[(mCyc + i) % 8] = 1'b1;
                        schRv[(mCyc + 1 + LAT) % 8]     = w;
                        schRvAddr[(mCyc + 1 + LAT) % 8] = ad;
                        nextFree = mCyc + 2 + LAT;
                    end
                end
            end
            mCyc++;
        end
    end

    initial begin
        int ids [5];
        int expIds [5];
        int n;
        bit sawF;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 32'h100};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 32'h200};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 32'h200};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'b001, 1'b1, 32'h300};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 32'h300};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 32'h200};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 1'b1, 32'h200};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1, 32'h300};
        expIds = '{1, 1, 1, 1, 0};

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        fAddr = 32'h0; dAddr = 32'h0; sAddr = 32'h0; dWdata = 32'h0; sWdata = 32'h0;
        repeat (2) nextCycle();
        rst = 1'b0;
        chkEn = 1'b1;
        for (int k = 0; k < NINST; k++)
            checkOutput($sformatf("reset state inst%0d", k),
                128'({gntF[k], gntD[k], gntS[k], rvF[k], rvD[k], rvS[k], busy[k], memEn[k], memWe[k],
                      memAddr[k], memWdata[k]}), 128'(0));

        // Single-cycle request patterns from IDLE: who wins and what is driven.
        fAddr = 32'h100; dAddr = 32'h200; sAddr = 32'h300; dWdata = 32'hAAAA0000; sWdata = 32'h5555;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].f, vecs[i].d, vecs[i].s, vecs[i].dw, vecs[i].sw);
            nextCycle();
            checkOutput($sformatf("vector %0d", i),
                128'({gntF[0], gntD[0], gntS[0], memWe[0], busy[0], memAddr[0]}),
                128'({vecs[i].expGnt, vecs[i].expWe, 1'b1, vecs[i].expAddr}));
            applyStimulus(0, 0, 0, 0, 0);
            repeat (6) nextCycle();
        end

        // Fetch read, latency 1.
        fAddr = 32'h10;
        applyStimulus(1, 0, 0, 0, 0);
        nextCycle();
        checkOutput("fetch gnt", 128'({gntF[0], memEn[0], busy[0], rvF[0], memAddr[0]}), 128'({4'b1110, 32'h10}));
        applyStimulus(0, 0, 0, 0, 0);
        nextCycle();
        checkOutput("fetch rvalid", 128'({rvF[0], busy[0], memEn[0], rdata[0]}), 128'({3'b110, 32'hDEADBEEF}));
        nextCycle();
        checkOutput("fetch done", 128'({rvF[0], busy[0]}), 128'(0));
        repeat (6) nextCycle();

        // D write together with S push and F read: served D, S, F, one per ISSUE.
        fAddr = 32'h60; dAddr = 32'h20; dWdata = 32'h1234; sAddr = 32'h3F0; sWdata = 32'h77;
        applyStimulus(1, 1, 1, 1, 1);
        nextCycle();
        checkOutput("triple d first", 128'({gntF[0], gntD[0], gntS[0], memWe[0], memAddr[0], memWdata[0]}),
                    128'({3'b010, 1'b1, 32'h20, 32'h1234}));
        applyStimulus(1, 0, 1, 0, 1);
        nextCycle();
        checkOutput("triple gap1", 128'({gntF[0], gntD[0], gntS[0]}), 128'(0));
        nextCycle();
        checkOutput("triple s second", 128'({gntF[0], gntD[0], gntS[0], memWe[0], memAddr[0]}),
                    128'({3'b001, 1'b1, 32'h3F0}));
        applyStimulus(1, 0, 0, 0, 0);
        nextCycle();
        checkOutput("triple gap2", 128'({gntF[0], gntD[0], gntS[0]}), 128'(0));
        nextCycle();
        checkOutput("triple f third", 128'({gntF[0], gntD[0], gntS[0], memWe[0], memAddr[0]}),
                    128'({3'b100, 1'b0, 32'h60}));
        applyStimulus(0, 0, 0, 0, 0);
        repeat (8) nextCycle();

        // Fetch held against continuous D/S traffic: fifth grant goes to fetch.
        for (int i = 0; i < 5; i++) ids[i] = -1;
        fAddr = 32'h80; dAddr = 32'h40; dWdata = 32'h99;
        applyStimulus(1, 1, 1, 1, 1);
        n = 0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            nextCycle();
            if (gntF[0]) begin ids[n] = 0; n++; end
            else if (gntD[0]) begin ids[n] = 1; n++; end
            else if (gntS[0]) begin ids[n] = 2; n++; end
        end
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("starve grant %0d", i), 128'(ids[i]), 128'(expIds[i]));
        repeat (8) nextCycle();

        // Stack pop with latency 3; a pending D write must wait out WAIT_RD.
        sAddr = 32'h3FC; dAddr = 32'h24; dWdata = 32'h5A;
        applyStimulus(0, 0, 1, 0, 0);
        nextCycle();
        checkOutput("pop gnt", 128'({gntS[1], memEn[1], memWe[1], memAddr[1]}), 128'({3'b110, 32'h3FC}));
        applyStimulus(0, 1, 0, 1, 0);
        for (int i = 2; i <= 4; i++) begin
            nextCycle();
            checkOutput($sformatf("pop wait t+%0d", i), 128'({memEn[1], gntD[1], rvS[1]}),
                        128'((i == 4) ? 3'b001 : 3'b000));
        end
        checkOutput("pop rdata", 128'(rdata[1]), 128'(memFunc(32'h3FC)));
        nextCycle();
        checkOutput("pop idle", 128'({gntD[1], busy[1]}), 128'(0));
        nextCycle();
        checkOutput("d after pop", 128'({gntD[1], memWe[1], memAddr[1]}), 128'({2'b11, 32'h24}));
        applyStimulus(0, 0, 0, 0, 0);
        repeat (8) nextCycle();

        // Reset during WAIT_RD on the latency-3 instance; fetch stays requested.
        fAddr = 32'h44;
        applyStimulus(1, 0, 0, 0, 0);
        nextCycle();
        checkOutput("rst pre gnt", 128'(gntF[1]), 128'(1));
        nextCycle();
        rst = 1'b1;
        nextCycle();
        checkOutput("rst clears", 128'({gntF[1], gntD[1], gntS[1], rvF[1], rvD[1], rvS[1], busy[1], memEn[1],
                                        memWe[1], memAddr[1], memWdata[1]}), 128'(0));
        rst = 1'b0;
        nextCycle();
        checkOutput("rst regrant", 128'({gntF[1], rvF[1]}), 128'(2'b10));
        applyStimulus(0, 0, 0, 0, 0);
        repeat (8) nextCycle();

        // Fetch pulse withdrawn while D wins: no fetch grant.
        dAddr = 32'h28;
        applyStimulus(1, 1, 0, 1, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0);
        sawF = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (gntF != '0) sawF = 1'b1;
            nextCycle();
        end
        checkOutput("withdrawn fetch", 128'(sawF), 128'(0));

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            fReq   = fReq ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
            dReq   = ($urandom_range(0, 99) < 45);
            sReq   = ($urandom_range(0, 99) < 40);
            dWe    = $urandom_range(0, 1) != 0;
            sWe    = $urandom_range(0, 1) != 0;
            fAddr  = 32'($urandom_range(0, 255));
            dAddr  = 32'($urandom_range(0, 255));
            sAddr  = 32'($urandom_range(0, 255));
            dWdata = $urandom;
            sWdata = $urandom;
            rst    = ($urandom_range(0, 199) == 0);
            nextCycle();
        end
        rst = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (8) nextCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
